// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM states and
// the control encoding used by the accumulator register.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        SHIFT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CTRL_LOAD  = 2'b00,
        CTRL_RESET = 2'b01,
        CTRL_SHIFT = 2'b10,
        CTRL_HOLD  = 2'b11
    } areg_ctrl_t;

endpackage

// File: rtl/booth_areg.sv
// Booth accumulator (A) register: load, clear, arithmetic right shift or hold.
module booth_areg
    import booth_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] din,
    input  logic             shift_in,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dout <= '0;
        end else begin
            case (control)
                CTRL_LOAD:  dout <= din;
                CTRL_RESET: dout <= '0;
                CTRL_SHIFT: dout <= {shift_in, dout[WIDTH-1:1]};
                default:    dout <= dout;
            endcase
        end
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed Booth multiplier: one EVAL (add/sub) and one SHIFT cycle
// per multiplier bit, result registered on entry to DONE.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int AW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);

    state_t          state, state_nx;
    areg_ctrl_t      a_ctrl;
    logic [AW-1:0]   a_q, a_din, m_q;
    logic [WIDTH-1:0] q_q;
    logic            q_1;
    logic [CW-1:0]   count;

    booth_areg #(.WIDTH(AW)) u_areg (
        .clock    (clock),
        .reset_n  (reset_n),
        .control  (a_ctrl),
        .din      (a_din),
        .shift_in (a_q[AW-1]),
        .dout     (a_q)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        a_ctrl   = CTRL_HOLD;
        a_din    = a_q;
        case (state)
            IDLE: begin
                if (start) begin
                    a_ctrl   = CTRL_RESET;
                    state_nx = EVAL;
                end
            end
            EVAL: begin
                busy     = 1'b1;
                state_nx = SHIFT;
                case ({q_q[0], q_1})
                    2'b10: begin
                        a_ctrl = CTRL_LOAD;
                        a_din  = a_q - m_q;
                    end
                    2'b01: begin
                        a_ctrl = CTRL_LOAD;
                        a_din  = a_q + m_q;
                    end
                    default: ;
                endcase
            end
            SHIFT: begin
                busy     = 1'b1;
                a_ctrl   = CTRL_SHIFT;
                state_nx = (count == CW'(1)) ? DONE : EVAL;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // product is taken from the post-shift view: {A>>>1}[WIDTH-1:0] is A[WIDTH:1],
    // and the shifted Q is {A[0], Q[WIDTH-1:1]}
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_q     <= '0;
            q_q     <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_q   <= {multiplicand[WIDTH-1], multiplicand};
                        q_q   <= multiplier;
                        q_1   <= 1'b0;
                        count <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    q_q   <= {a_q[0], q_q[WIDTH-1:1]};
                    q_1   <= q_q[0];
                    count <= count - CW'(1);
                    if (count == CW'(1))
                        product <= {a_q, q_q[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Randomized bench for booth_mult_seq (WIDTH=4 and WIDTH=8) against an
// integer-multiply reference.
module tb_booth_mult_seq;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;

    logic        start4 = 1'b0;
    logic [3:0]  mult4  = '0;
    logic [3:0]  mplr4  = '0;
    logic        busy4, done4;
    logic [7:0]  product4;

    logic        start8 = 1'b0;
    logic [7:0]  mult8  = '0;
    logic [7:0]  mplr8  = '0;
    logic        busy8, done8;
    logic [15:0] product8;

    int n_checks = 0;
    int n_errors = 0;

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start4),
        .multiplicand (mult4),
        .multiplier   (mplr4),
        .busy         (busy4),
        .done         (done4),
        .product      (product4)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start8),
        .multiplicand (mult8),
        .multiplier   (mplr8),
        .busy         (busy8),
        .done         (done8),
        .product      (product8)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sext(input logic [31:0] v, input int w);
        longint u;
        u = longint'(v) & ((longint'(1) << w) - 1);
        return v[w-1] ? u - (longint'(1) << w) : u;
    endfunction

    function automatic logic [63:0] ref_prod(input logic [31:0] m, input logic [31:0] q, input int w);
        longint p;
        logic [63:0] r;
        p = sext(m, w) * sext(q, w);
        r = 64'(p);
        return r & ((64'(1) << (2 * w)) - 1);
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 4) ? busy4 : busy8;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 4) ? done4 : done8;
    endfunction

    function automatic logic [63:0] get_prod(input int w);
        return (w == 4) ? 64'(product4) : 64'(product8);
    endfunction

    task automatic drive(input int w, input logic [31:0] m, input logic [31:0] q, input logic s);
        if (w == 4) begin
            mult4 = m[3:0]; mplr4 = q[3:0]; start4 = s;
        end else begin
            mult8 = m[7:0]; mplr8 = q[7:0]; start8 = s;
        end
    endtask

    // Called at #1 after an edge with the DUT idle; returns with the DUT idle.
    task automatic run_op(input int w, input logic [31:0] m, input logic [31:0] q,
                          input bit inject, input string tag);
        logic [63:0] exp, prev;
        int done_at, busy_cnt, extra;
        exp  = ref_prod(m, q, w);
        prev = get_prod(w);
        drive(w, m, q, 1'b1);
        @(posedge clock); #1;
        drive(w, $urandom, $urandom, 1'b0);
        done_at  = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 4 * w; i++) begin
            if (get_busy(w)) busy_cnt++;
            if (i == 1) check_eq({tag, "_hold"}, get_prod(w), prev);
            if (inject && i == 3) drive(w, $urandom, $urandom, 1'b1);
            @(posedge clock); #1;
            if (inject && i == 3) drive(w, $urandom, $urandom, 1'b0);
            if (get_done(w)) begin
                done_at = i;
                break;
            end
        end
        check_eq({tag, "_latency"}, 64'(done_at), 64'(2 * w));
        check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(2 * w));
        check_eq({tag, "_product"}, get_prod(w), exp);
        check_eq({tag, "_busy_in_done"}, 64'(get_busy(w)), 64'(0));
        extra = 0;
        for (int i = 0; i < 2 * w + 4; i++) begin
            @(posedge clock); #1;
            if (get_done(w)) extra++;
        end
        check_eq({tag, "_extra_done"}, 64'(extra), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int last, k;
        logic [31:0] om, oq;
        logic [63:0] e;

        #12;
        check_eq("rst_busy4", 64'(busy4), 64'(0));
        check_eq("rst_done4", 64'(done4), 64'(0));
        check_eq("rst_prod4", 64'(product4), 64'(0));
        check_eq("rst_busy8", 64'(busy8), 64'(0));
        check_eq("rst_done8", 64'(done8), 64'(0));
        check_eq("rst_prod8", 64'(product8), 64'(0));
        @(posedge clock); #1;
        reset_n = 1'b1;

        run_op(4, 32'd3, 32'd2, 1'b0, "w4_3x2");
        run_op(4, 32'(-8), 32'(-8), 1'b0, "w4_m8xm8");
        run_op(4, 32'(-8), 32'd7, 1'b0, "w4_m8x7");
        run_op(4, 32'd7, 32'(-1), 1'b0, "w4_7xm1");
        for (int i = 0; i < 12; i++)
            run_op(4, $urandom, $urandom, 1'b0, "w4_rand");

        run_op(4, 32'd5, 32'(-3), 1'b1, "w4_ignore_start");

        run_op(8, 32'(-128), 32'(-128), 1'b0, "w8_m128xm128");
        run_op(8, 32'd0, 32'(-1), 1'b0, "w8_0xm1");
        for (int i = 0; i < 6; i++)
            run_op(8, $urandom, $urandom, 1'b0, "w8_rand");

        // reset asserted on the 5th busy cycle
        run_op(4, 32'd7, 32'd7, 1'b0, "w4_pre_rst");
        drive(4, 32'd3, 32'd3, 1'b1);
        @(posedge clock); #1;
        drive(4, 32'd0, 32'd0, 1'b0);
        repeat (4) begin
            @(posedge clock); #1;
        end
        reset_n = 1'b0;
        #1;
        check_eq("midrst_busy", 64'(busy4), 64'(0));
        check_eq("midrst_done", 64'(done4), 64'(0));
        check_eq("midrst_prod", 64'(product4), 64'(0));
        @(posedge clock); #1;
        check_eq("midrst_done_later", 64'(done4), 64'(0));
        reset_n = 1'b1;
        run_op(4, 32'd5, 32'd3, 1'b0, "w4_after_rst");

        // start held high: one result every 10 cycles
        om = $urandom; oq = $urandom;
        e  = ref_prod(om, oq, 4);
        drive(4, om, oq, 1'b1);
        last = 0;
        k    = 0;
        for (int c = 1; c <= 60 && k < 3; c++) begin
            @(posedge clock); #1;
            if (done4) begin
                check_eq("cont_product", 64'(product4), e);
                if (k > 0) check_eq("cont_period", 64'(c - last), 64'(10));
                last = c;
                k++;
                om = $urandom; oq = $urandom;
                e  = ref_prod(om, oq, 4);
                drive(4, om, oq, k < 3);
            end
        end
        check_eq("cont_count", 64'(k), 64'(3));
        repeat (4) @(posedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
